// File: rtl/mem_arbiter.sv
// Unified-memory arbiter: round-robin between an instruction cache
// (four-beat 128-bit block refills) and a data cache (single-word
// block read or write-back) in front of one 32-bit word memory.
module mem_arbiter #(
   parameter int unsigned MEM_AW    = 10,
   parameter int unsigned INST_BASE = 0,
   parameter int unsigned DATA_BASE = 256
) (
   input  logic              CLK,
   input  logic              RESET,
   // instruction cache side
   input  logic              inst_read,
   input  logic [5:0]        inst_address,
   output logic [127:0]      inst_readdata,
   output logic              inst_busywait,
   // data cache side
   input  logic              data_read,
   input  logic              data_write,
   input  logic [5:0]        data_address,
   input  logic [31:0]       data_writedata,
   output logic [31:0]       data_readdata,
   output logic              data_busywait,
   // unified memory side
   output logic              mem_read,
   output logic              mem_write,
   output logic [MEM_AW-1:0] mem_address,
   output logic [31:0]       mem_writedata,
   input  logic [31:0]       mem_readdata,
   input  logic              mem_busywait,
   // ownership, for debug
   output logic              grant_inst,
   output logic              grant_data
);

   typedef enum logic [2:0] {
      IDLE,
      D_ACC,
      I_ACC,
      I_GAP,
      D_REL,
      I_REL
   } state_t;

   typedef enum logic {
      OWNER_INST,
      OWNER_DATA
   } owner_t;

   state_t            state;
   state_t            state_next;
   owner_t            last_grant;
   owner_t            last_grant_next;
   logic [1:0]        beat;
   logic [1:0]        beat_next;
   logic              acc_armed;
   logic              in_acc;
   logic              beat_done;
   logic              data_req;
   logic [MEM_AW-1:0] inst_word_addr;
   logic [MEM_AW-1:0] data_word_addr;

   // Request, beat-completion and address decode.
   always_comb begin
      data_req  = data_read || data_write;
      in_acc    = (state == D_ACC) || (state == I_ACC);
      // acc_armed is clear on the first edge of every access state, so a
      // memory that raises busywait one cycle late is never mistaken for done.
      beat_done = in_acc && acc_armed && !mem_busywait;
      // Sums are taken in MEM_AW bits so addresses wrap around the memory.
      inst_word_addr = MEM_AW'(INST_BASE)
                     + MEM_AW'({inst_address, 2'b00})
                     + MEM_AW'(beat);
      data_word_addr = MEM_AW'(DATA_BASE) + MEM_AW'(data_address);
   end

   // State register, round-robin pointer, beat index and first-edge guard.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state      <= IDLE;
         last_grant <= OWNER_INST;
         beat       <= '0;
         acc_armed  <= 1'b0;
      end else begin
         state      <= state_next;
         last_grant <= last_grant_next;
         beat       <= beat_next;
         acc_armed  <= in_acc && !beat_done;
      end
   end

   // Next-state logic: arbitration in IDLE, beat sequencing for refills.
   always_comb begin
      state_next      = state;
      last_grant_next = last_grant;
      beat_next       = beat;
      case (state)
         IDLE: begin
            // On a tie the requester that was not granted last time wins.
            if (data_req && (!inst_read || last_grant == OWNER_INST)) begin
               state_next      = D_ACC;
               last_grant_next = OWNER_DATA;
            end else if (inst_read) begin
               state_next      = I_ACC;
               last_grant_next = OWNER_INST;
               beat_next       = '0;
            end
         end
         D_ACC: begin
            if (beat_done) begin
               state_next = D_REL;
            end
         end
         I_ACC: begin
            if (beat_done) begin
               if (beat == 2'd3) begin
                  state_next = I_REL;
               end else begin
                  beat_next  = beat + 2'd1;
                  state_next = I_GAP;
               end
            end
         end
         I_GAP:   state_next = I_ACC;
         D_REL:   state_next = IDLE;
         I_REL:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Memory port: only the owner's inputs are steered onto it.
   always_comb begin
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_address   = '0;
      mem_writedata = '0;
      case (state)
         D_ACC: begin
            mem_read      = data_read;
            mem_write     = data_write;
            mem_address   = data_word_addr;
            mem_writedata = data_writedata;
         end
         I_ACC: begin
            mem_read    = 1'b1;
            mem_address = inst_word_addr;
         end
         default: begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
         end
      endcase
   end

   // Handshake back to the caches and debug ownership flags.
   always_comb begin
      // Busywait follows the request in the same cycle and drops only in the
      // release cycle; it is held low while reset is asserted.
      inst_busywait = inst_read && (state != I_REL) && !RESET;
      data_busywait = data_req && (state != D_REL) && !RESET;
      grant_inst    = (state == I_ACC) || (state == I_GAP) || (state == I_REL);
      grant_data    = (state == D_ACC) || (state == D_REL);
   end

   // Read-data capture: refill words land in their beat slice, data reads
   // replace the whole word; both hold until the owner's next completion.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         inst_readdata <= '0;
         data_readdata <= '0;
      end else begin
         if (beat_done && state == I_ACC) begin
            inst_readdata[32*beat +: 32] <= mem_readdata;
         end
         if (beat_done && state == D_ACC && data_read) begin
            data_readdata <= mem_readdata;
         end
      end
   end

endmodule
